// File: rtl/cpu_sig_responder_if.sv
// Single-wire cpu signal link seen from the responder: request line in,
// response line and status flags out.
interface cpu_sig_responder_if;
  logic       req_sig_i;
  logic       rsp_sig_o;
  logic       rsp_checker;
  logic       busy;
  logic [7:0] err_cnt;

  modport master (
    output req_sig_i,
    input  rsp_sig_o,
    input  rsp_checker,
    input  busy,
    input  err_cnt
  );

  modport slave (
    input  req_sig_i,
    output rsp_sig_o,
    output rsp_checker,
    output busy,
    output err_cnt
  );
endinterface

// File: rtl/cpu_sig_responder.sv
// Responder end of the single-wire cpu signal link: decodes serial request
// frames, reads/writes a small register file and answers serially.
module cpu_sig_responder #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 8,
  parameter int TURNAROUND = 2
) (
  input  logic                clk,
  input  logic                rst,
  cpu_sig_responder_if.slave  bus
);

  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int CNT_MAX = (ADDR_W > DATA_W) ?
                           ((ADDR_W > TURNAROUND) ? ADDR_W : TURNAROUND) :
                           ((DATA_W > TURNAROUND) ? DATA_W : TURNAROUND);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RX_RW,
    ST_RX_ADDR,
    ST_RX_DATA,
    ST_RX_PAR,
    ST_TURN,
    ST_TX_START,
    ST_TX_STAT,
    ST_TX_DATA,
    ST_TX_PAR
  } state_t;

  function automatic logic data_parity(input logic [DATA_W-1:0] v);
    return ^v;
  endfunction

  function automatic logic frame_parity(input logic              rw,
                                        input logic [ADDR_W-1:0] addr,
                                        input logic [DATA_W-1:0] data);
    return rw ^ (^addr) ^ data_parity(data);
  endfunction

  state_t              state_r, next_s;
  logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
  logic                rw_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   data_r;
  logic                par_ok_r;
  logic [DATA_W-1:0]   tx_sh_r;
  logic                tx_par_r;
  logic [DATA_W-1:0]   regs_r [DEPTH];
  logic                rsp_r, rsp_nxt_s;
  logic                chk_r;
  logic                busy_r;
  logic [7:0]          err_cnt_r;
  logic                ok_s;
  logic                par_err_s;
  logic                wr_s;

  // Parity verdict and register write strobe for the current cycle
  always_comb begin
    ok_s      = (frame_parity(rw_r, addr_r, data_r) == bus.req_sig_i);
    par_err_s = 1'b0;
    wr_s      = 1'b0;
    if (state_r == ST_RX_PAR) begin
      par_err_s = ~ok_s;
    end else begin
      par_err_s = 1'b0;
    end
    // The write lands in the first TURN cycle only.
    if ((state_r == ST_TURN) && (cnt_r == CNT_W'(TURNAROUND - 1)) && rw_r && par_ok_r) begin
      wr_s = 1'b1;
    end else begin
      wr_s = 1'b0;
    end
  end

  // Next-state and shift-counter sequencing
  always_comb begin
    next_s    = state_r;
    cnt_nxt_s = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.req_sig_i) begin
          next_s = ST_RX_RW;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_RX_RW: begin
        next_s    = ST_RX_ADDR;
        cnt_nxt_s = CNT_W'(ADDR_W - 1);
      end
      ST_RX_ADDR: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          if (rw_r) begin
            next_s    = ST_RX_DATA;
            cnt_nxt_s = CNT_W'(DATA_W - 1);
          end else begin
            next_s    = ST_RX_PAR;
          end
        end else begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end
      end
      ST_RX_DATA: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          next_s = ST_RX_PAR;
        end else begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end
      end
      ST_RX_PAR: begin
        next_s    = ST_TURN;
        cnt_nxt_s = CNT_W'(TURNAROUND - 1);
      end
      ST_TURN: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          next_s = ST_TX_START;
        end else begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end
      end
      ST_TX_START: begin
        next_s = ST_TX_STAT;
      end
      ST_TX_STAT: begin
        if (!rw_r && par_ok_r) begin
          next_s    = ST_TX_DATA;
          cnt_nxt_s = CNT_W'(DATA_W - 1);
        end else begin
          next_s    = ST_IDLE;
        end
      end
      ST_TX_DATA: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          next_s = ST_TX_PAR;
        end else begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end
      end
      ST_TX_PAR: begin
        next_s = ST_IDLE;
      end
      default: begin
        next_s    = ST_IDLE;
        cnt_nxt_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // Response bit for the upcoming state, so the registered line tracks the state
  always_comb begin
    rsp_nxt_s = 1'b0;
    case (next_s)
      ST_TX_START: rsp_nxt_s = 1'b1;
      ST_TX_STAT:  rsp_nxt_s = par_ok_r;
      ST_TX_DATA:  rsp_nxt_s = tx_sh_r[DATA_W-1];
      ST_TX_PAR:   rsp_nxt_s = tx_par_r;
      default:     rsp_nxt_s = 1'b0;
    endcase
  end

  // State, frame capture, register file and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      rw_r      <= 1'b0;
      addr_r    <= {ADDR_W{1'b0}};
      data_r    <= {DATA_W{1'b0}};
      par_ok_r  <= 1'b0;
      tx_sh_r   <= {DATA_W{1'b0}};
      tx_par_r  <= 1'b0;
      rsp_r     <= 1'b0;
      chk_r     <= 1'b0;
      busy_r    <= 1'b0;
      err_cnt_r <= 8'h00;
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      state_r <= next_s;
      cnt_r   <= cnt_nxt_s;
      rsp_r   <= rsp_nxt_s;
      busy_r  <= (next_s != ST_IDLE);
      chk_r   <= par_err_s;

      if (state_r == ST_IDLE) begin
        data_r <= {DATA_W{1'b0}};
      end else if (state_r == ST_RX_DATA) begin
        data_r <= {data_r[DATA_W-2:0], bus.req_sig_i};
      end

      if (state_r == ST_RX_RW) begin
        rw_r <= bus.req_sig_i;
      end
      if (state_r == ST_RX_ADDR) begin
        addr_r <= {addr_r[ADDR_W-2:0], bus.req_sig_i};
      end
      if (state_r == ST_RX_PAR) begin
        par_ok_r <= ok_s;
      end

      if (par_err_s && (err_cnt_r != 8'hFF)) begin
        err_cnt_r <= err_cnt_r + 8'h01;
      end

      if (wr_s) begin
        regs_r[addr_r] <= data_r;
      end

      if (state_r == ST_TX_START) begin
        tx_sh_r  <= regs_r[addr_r];
        tx_par_r <= data_parity(regs_r[addr_r]);
      end else if (next_s == ST_TX_DATA) begin
        tx_sh_r  <= {tx_sh_r[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign bus.rsp_sig_o   = rsp_r;
  assign bus.rsp_checker = chk_r;
  assign bus.busy        = busy_r;
  assign bus.err_cnt     = err_cnt_r;

endmodule
